// File: rtl/hex_keypad_scanner.sv
// Purpose: scans a 4x4 active-low hex keypad, debounces it and queues the keycodes in a small FIFO.
// Latency: a key is pushed on the DEBOUNCE_SCANS-th matching scan tick, and key_valid rises on the next cycle.
// Backpressure: key_valid/key_ready handshake; a push into a full FIFO with no pop is dropped and sets sticky overflow.
// Ports: clk, reset (sync, active-low), row_n[3:0] row drive, col_n[3:0] async column sense,
//        key_data[3:0]/key_valid/key_ready keycode stream, key_held debounced key down, overflow sticky drop flag.
// Build option: define KEY_REPEAT_EN to re-push a held key every REPEAT_SCANS scan ticks.
module hex_keypad_scanner #(
    parameter int SCAN_DIV_W     = 15,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int DEPTH          = 4,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] row_n,
    input  logic [3:0] col_n,
    output logic [3:0] key_data,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overflow
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_PRESSED  = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    logic [3:0]            col_meta, col_sync;
    logic [SCAN_DIV_W-1:0] div_cnt;
    logic                  tick;
    logic [1:0]            row_idx;
    logic [1:0]            state, state_nxt;
    logic [1:0]            lat_col, lat_col_nxt, col_enc;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  row_adv, push, rep_push, push_any;
    logic [3:0]            sample;
    logic                  one_hot, lat_hit, lat_match;

    // Sample is active-high: a bit set means that column is pulled low.
    assign tick      = &div_cnt;
    assign sample    = ~col_sync;
    assign one_hot   = (sample != 4'd0) && ((sample & (sample - 4'd1)) == 4'd0);
    assign lat_hit   = sample[lat_col];
    assign lat_match = (sample == (4'b0001 << lat_col));
    assign row_n     = ~(4'b0001 << row_idx);

    always_comb begin
        col_enc = 2'd0;
        case (sample)
            4'b0010: col_enc = 2'd1;
            4'b0100: col_enc = 2'd2;
            4'b1000: col_enc = 2'd3;
            default: col_enc = 2'd0;
        endcase
    end

    // The row index stays frozen outside IDLE, so it doubles as the latched row.
    // cnt is shared: press-confirm count in DEBOUNCE, release count in RELEASE.
    always_comb begin
        state_nxt   = state;
        lat_col_nxt = lat_col;
        cnt_nxt     = cnt;
        row_adv     = 1'b0;
        push        = 1'b0;
        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (one_hot) begin
                        lat_col_nxt = col_enc;
                        cnt_nxt     = CNT_W'(1);
                        state_nxt   = S_DEBOUNCE;
                    end else begin
                        row_adv = 1'b1;
                    end
                end
                S_DEBOUNCE: begin
                    if (lat_match) begin
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt_nxt == CNT_W'(DEBOUNCE_SCANS)) begin
                            push      = 1'b1;
                            state_nxt = S_PRESSED;
                        end
                    end else begin
                        state_nxt = S_IDLE;
                        row_adv   = 1'b1;
                    end
                end
                S_PRESSED: begin
                    if (!lat_hit) begin
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = S_RELEASE;
                    end
                end
                default: begin
                    if (!lat_hit) begin
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt_nxt == CNT_W'(DEBOUNCE_SCANS)) begin
                            state_nxt = S_IDLE;
                            row_adv   = 1'b1;
                        end
                    end else begin
                        state_nxt = S_PRESSED;
                    end
                end
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);
    logic [REP_W-1:0] rep_cnt, rep_nxt;

    // Held at zero outside PRESSED, which gives the clear on entry and on PRESSED->RELEASE.
    always_comb begin
        rep_nxt  = rep_cnt;
        rep_push = 1'b0;
        if (state != S_PRESSED) begin
            rep_nxt = '0;
        end else if (tick) begin
            if (!lat_hit) begin
                rep_nxt = '0;
            end else if (rep_cnt == REP_W'(REPEAT_SCANS - 1)) begin
                rep_push = 1'b1;
                rep_nxt  = '0;
            end else begin
                rep_nxt = rep_cnt + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) rep_cnt <= '0;
        else        rep_cnt <= rep_nxt;
    end
`else
    // REPEAT_SCANS only matters when auto-repeat is built in.
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_SCANS;
    assign rep_push      = 1'b0;
`endif

    assign push_any = push | rep_push;

    always_ff @(posedge clk) begin
        if (!reset) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
            div_cnt  <= '0;
            row_idx  <= 2'd0;
            state    <= S_IDLE;
            lat_col  <= 2'd0;
            cnt      <= '0;
            key_held <= 1'b0;
        end else begin
            col_meta <= col_n;
            col_sync <= col_meta;
            div_cnt  <= div_cnt + SCAN_DIV_W'(1);
            row_idx  <= row_idx + 2'(row_adv);
            state    <= state_nxt;
            lat_col  <= lat_col_nxt;
            cnt      <= cnt_nxt;
            key_held <= (state_nxt == S_PRESSED) || (state_nxt == S_RELEASE);
        end
    end

    // Keycode FIFO, first-word-fall-through with registered head.
    logic [3:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [PTR_W:0]   count, count_nxt, remain;
    logic             pop, full, accept;
    logic [3:0]       code, head_nxt;

    assign code      = {row_idx, lat_col};
    assign pop       = key_valid & key_ready;
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign accept    = push_any & (~full | pop);
    assign rd_nxt    = rd_ptr + PTR_W'(pop);
    assign remain    = count - (PTR_W+1)'(pop);
    assign count_nxt = remain + (PTR_W+1)'(accept);
    // When nothing older survives the pop, the incoming code becomes the head directly.
    assign head_nxt  = (remain == '0) ? code : mem[rd_nxt];

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= code;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            key_valid <= 1'b0;
            key_data  <= 4'd0;
            overflow  <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + PTR_W'(accept);
            rd_ptr    <= rd_nxt;
            count     <= count_nxt;
            key_valid <= (count_nxt != '0);
            if (count_nxt != '0) key_data <= head_nxt;
            overflow  <= overflow | (push_any & full & ~pop);
        end
    end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
module tb_hex_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_data;
    logic        key_valid;
    logic        key_ready;
    logic        key_held;
    logic        overflow;
    logic [15:0] keys;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    hex_keypad_scanner #(
        .SCAN_DIV_W    (2),
        .DEBOUNCE_SCANS(4),
        .DEPTH         (4),
        .REPEAT_SCANS  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_data (key_data),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_held (key_held),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Keypad matrix: key index = {row, col}, so a held key pulls its column low while its row is driven.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row_n[r])
                for (int c = 0; c < 4; c++)
                    if (keys[r*4+c]) col_n[c] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_held(input logic v, input string tag);
        int n = 0;
        while (key_held !== v && n < 300) begin
            step(1);
            n++;
        end
        chk(tag, key_held, v);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (key_valid !== 1'b1 && n < 300) begin
            step(1);
            n++;
        end
        chk(tag, key_valid, 1);
    endtask

    // Returns on the first cycle row r becomes the driven row.
    task automatic wait_row(input int r, input string tag);
        logic [3:0] target;
        int n = 0;
        target = ~(4'b0001 << r);
        while (row_n === target && n < 100) begin
            step(1);
            n++;
        end
        while (row_n !== target && n < 200) begin
            step(1);
            n++;
        end
        chk(tag, row_n, target);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        step(3);
        chk({tag, "_row_n"}, row_n, 4'b1110);
        chk({tag, "_valid"}, key_valid, 0);
        chk({tag, "_held"}, key_held, 0);
        chk({tag, "_ovf"}, overflow, 0);
        reset = 1'b1;
    endtask

    task automatic press_release(input int code, input string tag);
        keys[code] = 1'b1;
        wait_held(1, {tag, "_down"});
        keys[code] = 1'b0;
        wait_held(0, {tag, "_up"});
    endtask

    // Scoreboard: every accepted transfer must match the oldest expected keycode.
    always @(negedge clk) begin
        if (reset === 1'b1 && key_valid === 1'b1 && key_ready === 1'b1) begin
            logic [3:0] e;
            chk("entry_expected", {31'b0, exp_q.size() > 0}, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("key_data_pop", key_data, e);
            end
        end
    end

    initial begin
        reset     = 1'b0;
        keys      = 16'h0;
        key_ready = 1'b0;

        // 1: reset state and row rotation
        do_reset("rst");
        chk("rst_key_data", key_data, 0);
        step(3);
        chk("rot_hold", row_n, 4'b1110);
        step(1);
        chk("rot_row1", row_n, 4'b1101);
        step(4);
        chk("rot_row2", row_n, 4'b1011);
        step(4);
        chk("rot_row3", row_n, 4'b0111);
        step(4);
        chk("rot_row0", row_n, 4'b1110);

        // 2: key row2/col1 -> 0x9, single pop
        exp_q.push_back(4'h9);
        keys[9] = 1'b1;
        wait_valid("k9_valid");
        chk("k9_data", key_data, 4'h9);
        chk("k9_held", key_held, 1);
        key_ready = 1'b1;
        step(1);
        chk("k9_popped", key_valid, 0);
`ifndef KEY_REPEAT_EN
        step(400);
        chk("k9_no_repeat", key_valid, 0);
        chk("k9_still_held", key_held, 1);
`endif
        keys[9] = 1'b0;
        wait_held(0, "k9_release");
        chk("k9_q_empty", exp_q.size(), 0);

        // 3: bounce at row1/col3 for two ticks
        wait_row(1, "bnc_row1");
        keys[7] = 1'b1;
        step(8);
        chk("bnc_mid_held", key_held, 0);
        keys[7] = 1'b0;
        step(4);
        chk("bnc_row_adv", row_n, 4'b1011);
        chk("bnc_held", key_held, 0);
        chk("bnc_valid", key_valid, 0);

        // 4: ghosting on row0 (two columns low)
        keys[0] = 1'b1;
        keys[1] = 1'b1;
        wait_row(0, "gh_row0");
        step(4);
        chk("gh_row1", row_n, 4'b1101);
        step(4);
        chk("gh_row2", row_n, 4'b1011);
        step(4);
        chk("gh_row3", row_n, 4'b0111);
        step(4);
        chk("gh_row0b", row_n, 4'b1110);
        chk("gh_held", key_held, 0);
        chk("gh_valid", key_valid, 0);
        keys[0] = 1'b0;
        keys[1] = 1'b0;

        // 5: fill FIFO with consumer stalled, fifth key dropped
        key_ready = 1'b0;
        exp_q.push_back(4'h1);
        press_release(4'h1, "ov1");
        exp_q.push_back(4'h5);
        press_release(4'h5, "ov5");
        exp_q.push_back(4'hA);
        press_release(4'hA, "ovA");
        exp_q.push_back(4'hC);
        press_release(4'hC, "ovC");
        chk("ov_before", overflow, 0);
        press_release(4'hE, "ovE");
        chk("ov_after", overflow, 1);
        chk("ov_head", key_data, 4'h1);
        key_ready = 1'b1;
        step(6);
        chk("ov_drained", key_valid, 0);
        chk("ov_q_empty", exp_q.size(), 0);
        chk("ov_sticky", overflow, 1);
        key_ready = 1'b0;

        // 5b: push coinciding with a pop while full
        do_reset("rst2");
        exp_q.push_back(4'h1);
        press_release(4'h1, "pp1");
        exp_q.push_back(4'h5);
        press_release(4'h5, "pp5");
        exp_q.push_back(4'hA);
        press_release(4'hA, "ppA");
        exp_q.push_back(4'hC);
        press_release(4'hC, "ppC");
        exp_q.push_back(4'h2);
        wait_row(0, "pp_row0");
        keys[2] = 1'b1;
        step(15);
        chk("pp_pre_held", key_held, 0);
        key_ready = 1'b1;
        step(1);
        key_ready = 1'b0;
        chk("pp_held", key_held, 1);
        chk("pp_no_ovf", overflow, 0);
        chk("pp_valid", key_valid, 1);
        chk("pp_head", key_data, 4'h5);
        keys[2] = 1'b0;
        wait_held(0, "pp_release");
        key_ready = 1'b1;
        step(6);
        chk("pp_q_empty", exp_q.size(), 0);
        chk("pp_drained", key_valid, 0);

        // 6: long hold of 0xF (repeats only with auto-repeat)
        exp_q.push_back(4'hF);
`ifdef KEY_REPEAT_EN
        repeat (3) exp_q.push_back(4'hF);
`endif
        keys[15] = 1'b1;
        wait_held(1, "rp_down");
        step(104);
        keys[15] = 1'b0;
        wait_held(0, "rp_up");
        step(40);
        chk("rp_q_empty", exp_q.size(), 0);
        chk("rp_valid", key_valid, 0);

        // 6b: reset while a key is held, key re-detected afterwards
        exp_q.push_back(4'hF);
        keys[15] = 1'b1;
        wait_held(1, "mr_down");
        step(3);
        chk("mr_popped", exp_q.size(), 0);
        do_reset("mr_rst");
        exp_q.push_back(4'hF);
        wait_held(1, "mr_redetect");
        step(3);
        chk("mr_q_empty", exp_q.size(), 0);
        keys[15] = 1'b0;
        wait_held(0, "mr_up");

        step(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
